// File: rtl/rv_pkg.sv
// Shared widths and requester identifiers for the register-file writeback path.
package rv_pkg;

    localparam int XLEN_DEF = 32;
    localparam int NREG_DEF = 32;
    localparam int ADDR_W   = $clog2(NREG_DEF);

    typedef enum logic {
        REQ_ALU  = 1'b0,
        REQ_LOAD = 1'b1
    } req_idx_e;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin grant; the last-grant flop advances only when a grant is issued.
module rr_arbiter2
    import rv_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic valid0,
    input  logic valid1,
    output logic grant0,
    output logic grant1
);

    req_idx_e last_q;
    req_idx_e last_d;

    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        last_d = last_q;
        if (!reset) begin
            if (valid0 && valid1) begin
                grant0 = (last_q == REQ_LOAD);
                grant1 = (last_q == REQ_ALU);
            end else begin
                grant0 = valid0;
                grant1 = valid1;
            end
        end
        // A grant always coincides with its valid, so it is the handshake.
        if (grant0) begin
            last_d = REQ_ALU;
        end else if (grant1) begin
            last_d = REQ_LOAD;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            last_q <= REQ_LOAD;
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/rf_wb_arbiter.sv
// Writeback arbiter between ALU and load results, with a one-cycle output stage
// driving the register-file write port and a pending-write (busy) scoreboard.
module rf_wb_arbiter
    import rv_pkg::*;
#(
    parameter int XLEN = XLEN_DEF,
    parameter int NREG = NREG_DEF
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    req0_valid,
    input  logic [$clog2(NREG)-1:0] req0_addr,
    input  logic [XLEN-1:0]         req0_data,
    output logic                    req0_ready,
    input  logic                    req1_valid,
    input  logic [$clog2(NREG)-1:0] req1_addr,
    input  logic [XLEN-1:0]         req1_data,
    output logic                    req1_ready,
    output logic [$clog2(NREG)-1:0] write_addr,
    output logic [XLEN-1:0]         write_data,
    output logic                    reg_write,
    input  logic                    claim_valid,
    input  logic [$clog2(NREG)-1:0] claim_addr,
    input  logic [$clog2(NREG)-1:0] chk_addr_1,
    input  logic [$clog2(NREG)-1:0] chk_addr_2,
    output logic                    chk_busy_1,
    output logic                    chk_busy_2
);

    localparam int AW = $clog2(NREG);

    logic [AW-1:0]   write_addr_q, write_addr_d;
    logic [XLEN-1:0] write_data_q, write_data_d;
    logic            reg_write_q,  reg_write_d;
    logic [NREG-1:0] busy_q,       busy_d;

    rr_arbiter2 u_arb (
        .clk    (clk),
        .reset  (reset),
        .valid0 (req0_valid),
        .valid1 (req1_valid),
        .grant0 (req0_ready),
        .grant1 (req1_ready)
    );

    always_comb begin
        write_addr_d = write_addr_q;
        write_data_d = write_data_q;
        reg_write_d  = 1'b0;
        if (req0_ready) begin
            write_addr_d = req0_addr;
            write_data_d = req0_data;
            reg_write_d  = (req0_addr != '0);
        end else if (req1_ready) begin
            write_addr_d = req1_addr;
            write_data_d = req1_data;
            reg_write_d  = (req1_addr != '0);
        end
    end

    // Clear is applied before set so a same-cycle claim keeps the register pending.
    always_comb begin
        busy_d = busy_q;
        if (reg_write_q) begin
            busy_d[write_addr_q] = 1'b0;
        end
        if (claim_valid && (claim_addr != '0)) begin
            busy_d[claim_addr] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            write_addr_q <= '0;
            write_data_q <= '0;
            reg_write_q  <= 1'b0;
            busy_q       <= '0;
        end else begin
            write_addr_q <= write_addr_d;
            write_data_q <= write_data_d;
            reg_write_q  <= reg_write_d;
            busy_q       <= busy_d;
        end
    end

    assign write_addr = write_addr_q;
    assign write_data = write_data_q;
    assign reg_write  = reg_write_q;
    assign chk_busy_1 = busy_q[chk_addr_1];
    assign chk_busy_2 = busy_q[chk_addr_2];

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed bench for rf_wb_arbiter: arbitration order, output stage, busy scoreboard, reset.
module tb_rf_wb_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        req0_valid, req1_valid;
    logic [4:0]  req0_addr, req1_addr;
    logic [31:0] req0_data, req1_data;
    logic        req0_ready, req1_ready;
    logic [4:0]  write_addr;
    logic [31:0] write_data;
    logic        reg_write;
    logic        claim_valid;
    logic [4:0]  claim_addr, chk_addr_1, chk_addr_2;
    logic        chk_busy_1, chk_busy_2;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    rf_wb_arbiter #(.XLEN(32), .NREG(32)) dut (
        .clk         (clk),
        .reset       (reset),
        .req0_valid  (req0_valid),
        .req0_addr   (req0_addr),
        .req0_data   (req0_data),
        .req0_ready  (req0_ready),
        .req1_valid  (req1_valid),
        .req1_addr   (req1_addr),
        .req1_data   (req1_data),
        .req1_ready  (req1_ready),
        .write_addr  (write_addr),
        .write_data  (write_data),
        .reg_write   (reg_write),
        .claim_valid (claim_valid),
        .claim_addr  (claim_addr),
        .chk_addr_1  (chk_addr_1),
        .chk_addr_2  (chk_addr_2),
        .chk_busy_1  (chk_busy_1),
        .chk_busy_2  (chk_busy_2)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; checks happen 2 units later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    initial begin
        reset = 1'b1;
        req0_valid = 1'b1; req0_addr = 5'd3; req0_data = 32'hAAAA_0000;
        req1_valid = 1'b1; req1_addr = 5'd4; req1_data = 32'hBBBB_0000;
        claim_valid = 1'b0; claim_addr = '0;
        chk_addr_1 = 5'd0; chk_addr_2 = 5'd0;
        tick();
        settle();
        chk("rst_req0_ready", req0_ready, 1'b0);
        chk("rst_req1_ready", req1_ready, 1'b0);
        tick();
        chk("rst_reg_write", reg_write, 1'b0);
        chk("rst_write_addr", write_addr, 5'd0);
        chk("rst_write_data", write_data, 32'h0);

        // Single ALU request
        reset = 1'b0;
        req1_valid = 1'b0;
        req0_valid = 1'b1; req0_addr = 5'd5; req0_data = 32'hDEADBEEF;
        settle();
        chk("single_req0_ready", req0_ready, 1'b1);
        chk("single_req1_ready", req1_ready, 1'b0);
        tick();
        req0_valid = 1'b0;
        chk("single_reg_write", reg_write, 1'b1);
        chk("single_write_addr", write_addr, 5'd5);
        chk("single_write_data", write_data, 32'hDEADBEEF);
        tick();
        chk("idle_reg_write", reg_write, 1'b0);
        chk("idle_hold_addr", write_addr, 5'd5);
        chk("idle_hold_data", write_data, 32'hDEADBEEF);

        // Round-robin after reset
        reset = 1'b1;
        tick();
        reset = 1'b0;
        req0_valid = 1'b1; req0_addr = 5'd1; req0_data = 32'h11;
        req1_valid = 1'b1; req1_addr = 5'd2; req1_data = 32'h22;
        settle();
        chk("rr1_req0_ready", req0_ready, 1'b1);
        chk("rr1_req1_ready", req1_ready, 1'b0);
        tick();
        req0_data = 32'h33;
        chk("rr1_reg_write", reg_write, 1'b1);
        chk("rr1_write_addr", write_addr, 5'd1);
        chk("rr1_write_data", write_data, 32'h11);
        settle();
        chk("rr2_req0_ready", req0_ready, 1'b0);
        chk("rr2_req1_ready", req1_ready, 1'b1);
        tick();
        req1_data = 32'h44;
        chk("rr2_reg_write", reg_write, 1'b1);
        chk("rr2_write_addr", write_addr, 5'd2);
        chk("rr2_write_data", write_data, 32'h22);
        settle();
        chk("rr3_req0_ready", req0_ready, 1'b1);
        chk("rr3_req1_ready", req1_ready, 1'b0);
        tick();
        req0_valid = 1'b0; req1_valid = 1'b0;
        chk("rr3_reg_write", reg_write, 1'b1);
        chk("rr3_write_addr", write_addr, 5'd1);
        chk("rr3_write_data", write_data, 32'h33);

        // Write to x0 is accepted but not committed
        req1_valid = 1'b1; req1_addr = 5'd0; req1_data = 32'h1234;
        settle();
        chk("x0_req1_ready", req1_ready, 1'b1);
        tick();
        req1_valid = 1'b0;
        chk("x0_reg_write", reg_write, 1'b0);
        chk("x0_write_data", write_data, 32'h1234);

        // Claim then clear of register 7; claim of x0 is ignored
        claim_valid = 1'b1; claim_addr = 5'd7; chk_addr_1 = 5'd7;
        settle();
        chk("claim7_before", chk_busy_1, 1'b0);
        tick();
        claim_addr = 5'd0;
        chk("claim7_busy", chk_busy_1, 1'b1);
        tick();
        claim_valid = 1'b0;
        chk_addr_2 = 5'd0;
        chk("claim0_busy", chk_busy_2, 1'b0);
        req0_valid = 1'b1; req0_addr = 5'd7; req0_data = 32'h77;
        settle();
        chk("wr7_req0_ready", req0_ready, 1'b1);
        tick();
        req0_valid = 1'b0;
        chk("wr7_reg_write", reg_write, 1'b1);
        chk("wr7_busy_pending", chk_busy_1, 1'b1);
        tick();
        chk("wr7_busy_cleared", chk_busy_1, 1'b0);

        // Same-cycle claim and clear of register 9: claim wins
        claim_valid = 1'b1; claim_addr = 5'd9; chk_addr_2 = 5'd9;
        tick();
        claim_valid = 1'b0;
        chk("claim9_busy", chk_busy_2, 1'b1);
        req0_valid = 1'b1; req0_addr = 5'd9; req0_data = 32'h99;
        tick();
        req0_valid = 1'b0;
        claim_valid = 1'b1; claim_addr = 5'd9;
        chk("wr9_reg_write", reg_write, 1'b1);
        tick();
        claim_valid = 1'b0;
        chk("race9_busy", chk_busy_2, 1'b1);
        chk_addr_1 = 5'd0;
        settle();
        chk("chk_x0_busy", chk_busy_1, 1'b0);

        // Handshake to register 4, then reset before it is observed twice
        claim_valid = 1'b1; claim_addr = 5'd4; chk_addr_1 = 5'd4;
        req0_valid = 1'b1; req0_addr = 5'd4; req0_data = 32'h4444;
        tick();
        claim_valid = 1'b0;
        req0_valid = 1'b0;
        chk("wr4_reg_write", reg_write, 1'b1);
        chk("wr4_busy", chk_busy_1, 1'b1);
        reset = 1'b1;
        req0_valid = 1'b1; req0_addr = 5'd1; req0_data = 32'h5555;
        req1_valid = 1'b1; req1_addr = 5'd2; req1_data = 32'h6666;
        settle();
        chk("rst2_req0_ready", req0_ready, 1'b0);
        chk("rst2_req1_ready", req1_ready, 1'b0);
        tick();
        reset = 1'b0;
        chk("rst2_reg_write", reg_write, 1'b0);
        chk("rst2_write_addr", write_addr, 5'd0);
        chk("rst2_busy4", chk_busy_1, 1'b0);
        chk("rst2_busy9", chk_busy_2, 1'b0);
        settle();
        chk("rst2_tie_req0", req0_ready, 1'b1);
        chk("rst2_tie_req1", req1_ready, 1'b0);
        tick();
        req0_valid = 1'b0; req1_valid = 1'b0;
        chk("rst2_first_write_addr", write_addr, 5'd1);
        chk("rst2_first_write_data", write_data, 32'h5555);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
